bram_dump_reader: RTL and testbench



---
 rtl/bram_dump_if.sv | 35 +++
 rtl/bram_dump_reader.sv | 132 +++++++++++++
 tb/tb_bram_dump_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_dump_if
// Brief    : Control, debug-port and stream signals of the BRAM dump reader.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_dump_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] word_count;
    logic [ADDR_WIDTH-1:0] debug_addr;
    logic [DATA_WIDTH-1:0] debug_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] checksum;

    // The dump engine drives the debug address and the output stream.
    modport master (
        input  start, base_addr, word_count, debug_data, m_ready,
        output debug_addr, m_valid, m_data, m_addr, busy, done, checksum
    );

    modport slave (
        output start, base_addr, word_count, debug_data, m_ready,
        input  debug_addr, m_valid, m_data, m_addr, busy, done, checksum
    );
endinterface
`default_nettype wire

// File: rtl/bram_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_dump_reader
// Brief    : Walks a word-aligned BRAM range over the debug port and streams
//            (address, word) beats; BRAM_DUMP_CHECKSUM_EN adds a running sum.
// Revision : 1.0 - initial release
// ============================================================================
module bram_dump_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    bram_dump_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_word_step  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] c_last_word  = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic                  w_handshake;
    logic                  w_accept_start;

    assign w_handshake    = r_m_valid && bus.m_ready;
    assign w_accept_start = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.word_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SEND;
            S_SEND: begin
                if (w_handshake) begin
                    w_next = (r_remaining == c_last_word) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // r_addr doubles as the debug address, so it stays put from ISSUE
    // through CAPTURE and while a beat is stalled in SEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.word_count != '0)) begin
                        r_addr      <= bus.base_addr & c_align_mask;
                        r_remaining <= bus.word_count;
                    end
                end
                S_CAPTURE: begin
                    r_m_data  <= bus.debug_data;
                    r_m_addr  <= r_addr;
                    r_m_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_m_valid   <= 1'b0;
                        r_remaining <= r_remaining - c_last_word;
                        if (r_remaining != c_last_word) begin
                            r_addr <= r_addr + c_word_step;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BRAM_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // Cleared on every accepted start; the final sum then holds until the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_accept_start) begin
            r_checksum <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_checksum <= r_checksum + bus.debug_data;
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = '0;
`endif

    assign bus.debug_addr = r_addr;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_data     = r_m_data;
    assign bus.m_addr     = r_m_addr;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_bram_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_dump_reader
// Brief    : Randomised scoreboard bench for bram_dump_reader against a BRAM
//            array and an address/data list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_dump_reader;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_dump_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:255];
    always_comb bus.debug_data = mem[bus.debug_addr[AW-1:2]];

    beat_t   exp_q[$];
    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    int      dump_id = 0;
    int      hs_count = 0;
    int      last_hs_edge = 0;
    int      start_edge = 0;
    int      ready_mode = 0;
    int      stall_cnt = 0;
    logic [AW-1:0] stall_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // m_ready: 0 = always ready, 1 = random, 2 = five stall cycles on stall_addr
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            bus.m_ready = 1'b1;
            stall_cnt   = 0;
        end else if (ready_mode == 1) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            stall_cnt   = 0;
        end else if (bus.m_valid && bus.m_addr == stall_addr && stall_cnt < 5) begin
            bus.m_ready = 1'b0;
            stall_cnt++;
        end else begin
            bus.m_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability.
    logic          was_stall = 1'b0;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_addr, held_dbg;
    int            mon_dump = -1;
    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst) begin
            was_stall = 1'b0;
            mon_dump  = -1;
        end else begin
            if (bus.m_valid && !bus.m_ready) begin
                if (was_stall) begin
                    check("stall_data", bus.m_data, held_data);
                    check("stall_addr", bus.m_addr, held_addr);
                    check("stall_debug_addr", bus.debug_addr, held_dbg);
                end
                held_data = bus.m_data;
                held_addr = bus.m_addr;
                held_dbg  = bus.debug_addr;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat: unexpected beat addr 0x%0h data 0x%0h, none required",
                             bus.m_addr, bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr", bus.m_addr, e.addr);
                    check("beat_data", bus.m_data, e.data);
                end
                if (mon_dump == dump_id && ready_mode == 0)
                    check("beat_interval", cyc + 1 - last_hs_edge, 3);
                mon_dump     = dump_id;
                last_hs_edge = cyc + 1;
                hs_count++;
            end
        end
    end

    task automatic issue_start(input logic [AW-1:0] base, input logic [AW-1:0] wc);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = wc;
        start_edge     = cyc + 1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.base_addr  = AW'($urandom);
        bus.word_count = AW'($urandom);
    endtask

    task automatic push_model(input logic [AW-1:0] base, input logic [AW-1:0] wc,
                              output logic [DW-1:0] sum);
        logic [AW-1:0] a;
        a   = base & ~AW'(3);
        sum = '0;
        for (int i = 0; i < int'(wc); i++) begin
            exp_q.push_back({a, mem[a[AW-1:2]]});
            sum = sum + mem[a[AW-1:2]];
            a   = a + AW'(4);
        end
        dump_id++;
    endtask

    task automatic run_dump(input logic [AW-1:0] base, input logic [AW-1:0] wc, input bit disturb);
        logic [DW-1:0] sum;
        int n;
        push_model(base, wc, sum);
        issue_start(base, wc);
        check("busy_after_start", bus.busy, 1);
        if (wc != 0) begin
            check("valid_lat_e1", bus.m_valid, 0);
            @(negedge clk);
            check("valid_lat_e2", bus.m_valid, 0);
            @(negedge clk);
            check("valid_lat_e3", bus.m_valid, 1);
        end
        if (disturb) begin
            @(negedge clk);
            bus.start      = 1'b1;
            bus.word_count = AW'($urandom_range(1, 20));
            @(negedge clk);
            bus.start      = 1'b0;
        end
        n = 0;
        while (!bus.done && n < 20 * int'(wc) + 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done still 0 after %0d cycles, required 1", n);
            exp_q.delete();
        end else begin
            check("done_latency", cyc, (wc == 0) ? start_edge : last_hs_edge);
            check("beats_left", exp_q.size(), 0);
            check("valid_at_done", bus.m_valid, 0);
`ifdef BRAM_DUMP_CHECKSUM_EN
            if (wc != 0) check("checksum", bus.checksum, sum);
`else
            check("checksum_zero", bus.checksum, 0);
`endif
            @(negedge clk);
            check("done_pulse", bus.done, 0);
            check("busy_idle", bus.busy, 0);
        end
    endtask

    initial begin
        int n;
        logic [DW-1:0] sum;
        logic [AW-1:0] rb, rw;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_002A;
        mem[1] = 32'h0000_0002;
        mem[2] = 32'hFFFF_FFD6;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        repeat (3) @(negedge clk);
        check("rst_debug_addr", bus.debug_addr, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_checksum", bus.checksum, 0);
        rst = 1'b0;

        ready_mode = 0;
        run_dump(10'h000, 10'd3, 1'b0);

        ready_mode = 2;
        stall_addr = 10'h004;
        run_dump(10'h000, 10'd3, 1'b0);
        check("stall_cycles", stall_cnt, 5);
        ready_mode = 0;

        run_dump(10'h000, 10'd0, 1'b0);
        run_dump(10'h3FE, 10'd2, 1'b0);

        // Reset in the middle of a dump, then restart elsewhere.
        push_model(10'h000, 10'd3, sum);
        n = hs_count;
        issue_start(10'h000, 10'd3);
        for (int i = 0; i < 40 && hs_count == n; i++) @(negedge clk);
        check("hs_before_reset", (hs_count > n) ? 1 : 0, 1);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_debug_addr", bus.debug_addr, 0);
        check("arst_m_valid", bus.m_valid, 0);
        check("arst_m_data", bus.m_data, 0);
        check("arst_m_addr", bus.m_addr, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_checksum", bus.checksum, 0);
        @(negedge clk);
        rst = 1'b0;
        run_dump(10'h004, 10'd1, 1'b0);

        for (int k = 0; k < 14; k++) begin
            ready_mode = int'($urandom_range(0, 1));
            rb = AW'($urandom);
            rw = (k == 5) ? AW'(260) : AW'($urandom_range(0, 8));
            run_dump(rb, rw, rw >= 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
